// File: rtl/countdown_run_ctrl.sv
// countdown_run_ctrl
//   Control stage that sits in front of the 4-bit countdown counter and the
//   7-segment decoder. It synchronises and debounces the start and pause
//   buttons and runs the start/pause/done state machine. It issues the
//   counter preset (load) and the count-down enables (tick). A prescaler
//   sets the tick rate.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start_raw  in   raw start/restart button (async, active-high)
//   pause_raw  in   raw pause/resume button (async, active-high)
//   div_sel    in   tick period select: 0/1/2/3 -> 1/4/16/64 clk cycles
//   zero_in    in   downstream counter holds 0
//   load       out  one-cycle counter preset pulse
//   tick       out  one-cycle count-down enable
//   running    out  high in RUN
//   done       out  high in DONE
//   state      out  low 2 bits of the FSM state (DONE reads as 0)
module countdown_run_ctrl #(
    parameter int DB_CYCLES = 4,
    parameter int PRE_W     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_raw,
    input  logic       pause_raw,
    input  logic [1:0] div_sel,
    input  logic       zero_in,
    output logic       load,
    output logic       tick,
    output logic       running,
    output logic       done,
    output logic [1:0] state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

    // Bit 0 carries the start button, bit 1 the pause button.
    logic [1:0]      raw_btn;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      db_lvl;
    logic [1:0]      db_lvl_d;
    logic [1:0]      press;
    logic [1:0][7:0] db_cnt;
    logic            start_press;
    logic            pause_press;

    state_t           state_q;
    state_t           state_d;
    logic [PRE_W-1:0] pc;
    logic [PRE_W-1:0] pc_last;
    logic             pc_wrap;

    assign raw_btn = {pause_raw, start_raw};

    // The counter holds the number of differing samples seen so far. The
    // sample that arrives while it already equals DB_CYCLES-1 is the
    // DB_CYCLES-th, and that sample flips the level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            db_lvl   <= '0;
            db_lvl_d <= '0;
            db_cnt   <= '0;
        end else begin
            sync1    <= raw_btn;
            sync2    <= sync1;
            db_lvl_d <= db_lvl;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_lvl[i] <= ~db_lvl[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 8'd1;
                end
            end
        end
    end

    // Only rising debounced levels count as presses.
    assign press       = db_lvl & ~db_lvl_d;
    assign start_press = press[0];
    assign pause_press = press[1];

    always_comb begin
        pc_last = '0;
        case (div_sel)
            2'd0: pc_last = PRE_W'(0);
            2'd1: pc_last = PRE_W'(3);
            2'd2: pc_last = PRE_W'(15);
            2'd3: pc_last = PRE_W'(63);
            default: pc_last = '0;
        endcase
    end

    // ">=" rather than "==": when div_sel drops mid-run, a count that is
    // already past the new terminal value ticks right away.
    assign pc_wrap = (pc >= pc_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Same-cycle priority: start press > zero_in > pause press.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        tick    = 1'b0;
        running = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_press) state_d = LOAD;
            end
            LOAD: begin
                load    = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                running = 1'b1;
                tick    = !zero_in && pc_wrap;
                if (start_press)      state_d = LOAD;
                else if (zero_in)     state_d = DONE;
                else if (pause_press) state_d = PAUSE;
            end
            PAUSE: begin
                if (start_press)      state_d = LOAD;
                else if (pause_press) state_d = RUN;
            end
            DONE: begin
                done = 1'b1;
                if (start_press) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    assign state = state_q[1:0];

    // The prescaler clears in LOAD, counts in RUN while zero_in is low, and
    // otherwise holds. Holding keeps the phase across a pause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (state_q == LOAD) begin
            pc <= '0;
        end else if (state_q == RUN && !zero_in) begin
            pc <= tick ? '0 : pc + PRE_W'(1);
        end
    end

endmodule

// File: tb/tb_countdown_run_ctrl.sv
// tb_countdown_run_ctrl
//   Scoreboard bench for countdown_run_ctrl. A driver applies stimulus at
//   each falling edge and pushes the expected outputs for that cycle, taken
//   from a behavioural model, into a queue. A monitor pops each entry and
//   compares it with the DUT outputs shortly after the same falling edge.
//   Directed scenarios run first, then randomised button, zero and divider
//   traffic.
module tb_countdown_run_ctrl;

    localparam int DB = 4;

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_RUN   = 2;
    localparam int M_PAUSE = 3;
    localparam int M_DONE  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_raw;
    logic       pause_raw;
    logic [1:0] div_sel;
    logic       zero_in;
    logic       load;
    logic       tick;
    logic       running;
    logic       done;
    logic [1:0] state;

    always #5 clk = ~clk;

    countdown_run_ctrl #(
        .DB_CYCLES(DB),
        .PRE_W    (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_raw(start_raw),
        .pause_raw(pause_raw),
        .div_sel  (div_sel),
        .zero_in  (zero_in),
        .load     (load),
        .tick     (tick),
        .running  (running),
        .done     (done),
        .state    (state)
    );

    int checks = 0;
    int errors = 0;
    int nprint = 0;

    logic [5:0] exp_q[$];

    // Behavioural model state.
    int       m_mode;
    int       m_phase;
    bit [1:0] m_pipe_s;
    bit [1:0] m_pipe_p;
    bit       m_lvl_s;
    bit       m_lvl_p;
    bit       m_prev_s;
    bit       m_prev_p;
    int       m_run_s;
    int       m_run_p;

    int cur_mode;
    int cur_phase;

    task automatic model_clear();
        m_mode   = M_IDLE;
        m_phase  = 0;
        m_pipe_s = '0;
        m_pipe_p = '0;
        m_lvl_s  = 1'b0;
        m_lvl_p  = 1'b0;
        m_prev_s = 1'b0;
        m_prev_p = 1'b0;
        m_run_s  = 0;
        m_run_p  = 0;
    endtask

    function automatic int period_of(input logic [1:0] d);
        return 1 << (2 * int'(d));
    endfunction

    function automatic logic [5:0] model_out(input bit z, input logic [1:0] d);
        logic tk;
        tk = (m_mode == M_RUN) && !z && (m_phase >= period_of(d) - 1);
        return {m_mode == M_LOAD, tk, m_mode == M_RUN, m_mode == M_DONE, 2'(m_mode % 4)};
    endfunction

    // A level flips after DB consecutive samples that disagree with it.
    task automatic db_step(input bit samp, inout bit lvl, inout int run);
        if (samp == lvl) begin
            run = 0;
        end else begin
            run = run + 1;
            if (run == DB) begin
                lvl = !lvl;
                run = 0;
            end
        end
    endtask

    task automatic model_step(input bit st, input bit ps, input bit z,
                              input logic [1:0] d, input bit rst_ok);
        bit sp;
        bit pp;
        bit tk;
        int nm;
        if (!rst_ok) begin
            model_clear();
            return;
        end
        sp = m_lvl_s && !m_prev_s;
        pp = m_lvl_p && !m_prev_p;
        tk = (m_mode == M_RUN) && !z && (m_phase >= period_of(d) - 1);
        nm = m_mode;
        case (m_mode)
            M_IDLE:  if (sp) nm = M_LOAD;
            M_LOAD:  nm = M_RUN;
            M_RUN:   if (sp) nm = M_LOAD; else if (z) nm = M_DONE; else if (pp) nm = M_PAUSE;
            M_PAUSE: if (sp) nm = M_LOAD; else if (pp) nm = M_RUN;
            M_DONE:  if (sp) nm = M_LOAD;
            default: nm = M_IDLE;
        endcase
        if (m_mode == M_LOAD) m_phase = 0;
        else if (m_mode == M_RUN && !z) m_phase = tk ? 0 : m_phase + 1;
        m_mode   = nm;
        m_prev_s = m_lvl_s;
        m_prev_p = m_lvl_p;
        db_step(m_pipe_s[1], m_lvl_s, m_run_s);
        db_step(m_pipe_p[1], m_lvl_p, m_run_p);
        m_pipe_s = {m_pipe_s[0], st};
        m_pipe_p = {m_pipe_p[0], ps};
    endtask

    // One clock cycle: drive inputs at the falling edge, queue the expected
    // outputs for this cycle, then advance the model across the next rising edge.
    task automatic cyc(input bit st, input bit ps, input logic [1:0] d, input bit z);
        @(negedge clk);
        start_raw = st;
        pause_raw = ps;
        div_sel   = d;
        zero_in   = z;
        cur_mode  = m_mode;
        cur_phase = m_phase;
        exp_q.push_back(rst_n ? model_out(z, d) : 6'b0);
        model_step(st, ps, z, d, rst_n);
    endtask

    task automatic spot(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at t=%0t", nm, act, req, $time);
        end
    endtask

    // Monitor: compares every queued expectation with the DUT outputs.
    initial begin : monitor
        logic [5:0] e;
        logic [5:0] a;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {load, tick, running, done, state};
                checks++;
                if (a !== e) begin
                    errors++;
                    if (nprint < 40) begin
                        nprint++;
                        $display("FAIL outputs {load,tick,running,done,state} got %b expected %b at t=%0t",
                                 a, e, $time);
                    end
                end
            end
        end
    end

    initial begin : driver
        bit         found;
        int         nt;
        int         r;
        bit         z;
        bit         s;
        bit         p;
        int         sh;
        int         ph;
        logic [1:0] d;

        rst_n     = 1'b0;
        start_raw = 1'b0;
        pause_raw = 1'b0;
        div_sel   = 2'd0;
        zero_in   = 1'b0;
        model_clear();

        repeat (3) cyc(0, 0, 2'd0, 0);
        #3;
        spot("reset_state", int'(state), 0);
        spot("reset_outputs", int'({load, tick, running, done}), 0);
        rst_n = 1'b1;

        // Start held high from edge 1: load in cycle 7-8, running after edge 8.
        for (int unsigned c = 1; c <= 12; c++) begin
            cyc(1, 0, 2'd0, 0);
            #3;
            if (c == 7) spot("load_before_edge7", int'(load), 0);
            if (c == 8) spot("load_after_edge7", int'(load), 1);
            if (c == 9) begin
                spot("load_one_cycle", int'(load), 0);
                spot("running_after_load", int'(running), 1);
            end
        end
        repeat (10) cyc(0, 0, 2'd0, 0);
        // Three-cycle glitch must not restart.
        nt = 0;
        repeat (3) begin cyc(1, 0, 2'd0, 0); #3; nt += int'(load); end
        repeat (10) begin cyc(0, 0, 2'd0, 0); #3; nt += int'(load); end
        spot("glitch_no_load", nt, 0);
        spot("glitch_still_running", int'(running), 1);

        // div_sel=2: ticks every 16 cycles, first one 16 cycles into RUN.
        found = 0;
        for (int unsigned i = 0; i < 20 && !found; i++) begin
            cyc(1, 0, 2'd2, 0);
            if (cur_mode == M_LOAD) found = 1;
        end
        spot("reach_load_div2", int'(found), 1);
        for (int unsigned i = 1; i <= 48; i++) begin
            cyc(0, 0, 2'd2, 0);
            #3;
            spot("tick_every16", int'(tick), (i % 16 == 0) ? 1 : 0);
        end
        found = 0;
        for (int unsigned i = 0; i < 20 && !found; i++) begin
            if (m_phase == 10) found = 1;
            else cyc(0, 0, 2'd2, 0);
        end
        spot("reach_pc10", int'(found), 1);
        cyc(0, 0, 2'd0, 0);
        #3;
        spot("div_drop_immediate_tick", int'(tick), 1);
        for (int unsigned i = 0; i < 4; i++) begin
            cyc(0, 0, 2'd0, 0);
            #3;
            spot("div0_every_cycle", int'(tick), 1);
        end

        // div_sel=1 with a pause press in the second RUN cycle.
        nt = 0;
        for (int unsigned c = 1; c <= 25; c++) begin
            cyc(c <= 12, c >= 4 && c <= 12, 2'd1, 0);
            #3;
            if (c == 8) spot("pause_test_load", int'(load), 1);
            if (c == 10) spot("pause_test_running", int'(running), 1);
            if (c >= 11) nt += int'(tick);
        end
        spot("no_tick_in_pause", nt, 0);
        spot("state_pause", int'(state), 3);
        found = 0;
        for (int unsigned i = 0; i < 20 && !found; i++) begin
            cyc(0, 1, 2'd1, 0);
            #3;
            if (cur_mode == M_RUN) found = 1;
            else nt += int'(tick);
        end
        spot("resume_reached", int'(found), 1);
        spot("no_tick_until_resume", nt, 0);
        spot("resume_first_cycle_no_tick", int'(tick), 0);
        cyc(0, 1, 2'd1, 0);
        #3;
        spot("resume_second_cycle_tick", int'(tick), 1);
        repeat (10) cyc(0, 0, 2'd1, 0);

        // zero_in coincides with pc = P-1: tick suppressed, then DONE holds.
        found = 0;
        for (int unsigned i = 0; i < 10 && !found; i++) begin
            z = (m_mode == M_RUN) && (m_phase == 3);
            cyc(0, 0, 2'd1, z);
            #3;
            if (z) begin
                found = 1;
                spot("zero_suppresses_tick", int'(tick), 0);
            end
        end
        spot("zero_at_wrap_found", int'(found), 1);
        cyc(0, 0, 2'd1, 0);
        #3;
        spot("done_entered", int'(done), 1);
        spot("done_state_port", int'(state), 0);
        repeat (8) cyc(0, 0, 2'd1, 0);
        #3;
        spot("done_held", int'(done), 1);
        found = 0;
        for (int unsigned i = 0; i < 20 && !found; i++) begin
            cyc(1, 0, 2'd1, 0);
            #3;
            if (cur_mode == M_LOAD) found = 1;
        end
        spot("restart_from_done", int'(found), 1);
        spot("restart_load", int'(load), 1);
        spot("restart_done_low", int'(done), 0);
        repeat (10) cyc(0, 0, 2'd1, 0);

        // Start and pause presses together: LOAD wins, then RUN.
        found = 0;
        for (int unsigned i = 0; i < 20 && !found; i++) begin
            cyc(1, 1, 2'd0, 0);
            #3;
            if (cur_mode == M_LOAD) found = 1;
        end
        spot("both_press_load", int'(state), 1);
        cyc(1, 1, 2'd0, 0);
        #3;
        spot("both_press_then_run", int'(state), 2);
        repeat (10) cyc(0, 0, 2'd0, 0);
        #3;
        spot("both_press_stays_run", int'(state), 2);

        // zero_in together with a start press: LOAD, not DONE.
        found = 0;
        for (int unsigned i = 0; i < 20 && !found; i++) begin
            z = (m_mode == M_RUN) && m_lvl_s && !m_prev_s;
            cyc(1, 0, 2'd0, z);
            if (z) found = 1;
        end
        spot("start_zero_same_cycle", int'(found), 1);
        cyc(1, 0, 2'd0, 0);
        #3;
        spot("start_beats_zero", int'(state), 1);
        spot("start_beats_zero_done", int'(done), 0);
        repeat (10) cyc(0, 0, 2'd0, 0);

        // Asynchronous reset between edges while running with div_sel=0.
        cyc(0, 0, 2'd0, 0);
        #3;
        spot("pre_reset_running", int'(running), 1);
        rst_n = 1'b0;
        model_clear();
        #1;
        spot("async_reset_outputs", int'({load, tick, running, done}), 0);
        spot("async_reset_state", int'(state), 0);
        repeat (2) cyc(0, 0, 2'd0, 0);
        rst_n = 1'b1;
        nt = 0;
        repeat (20) begin cyc(0, 0, 2'd0, 0); #3; nt += int'(load) + int'(tick) + int'(running); end
        spot("quiet_after_reset", nt, 0);

        // Randomised traffic.
        s  = 1'b0;
        p  = 1'b0;
        sh = 0;
        ph = 0;
        d  = 2'd0;
        for (int unsigned i = 0; i < 2500; i++) begin
            if (sh == 0) begin
                s  = 1'($urandom_range(0, 1));
                sh = int'($urandom_range(1, 10));
            end
            if (ph == 0) begin
                p  = 1'($urandom_range(0, 1));
                ph = int'($urandom_range(1, 10));
            end
            sh--;
            ph--;
            if ($urandom_range(0, 49) == 0) d = 2'($urandom_range(0, 3));
            z = ($urandom_range(0, 39) == 0);
            cyc(s, p, d, z);
        end

        @(negedge clk);
        #3;
        spot("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
